led_mode_ctrl: RTL and testbench

Front-panel controller for one push-switch and one LED on the DE0 board (50 MHz clock).
- Synchronises and debounces the raw active-low switch.
- Classifies each press as short or long.
- Sequences the LED through four modes: OFF, ON, BLINK_SLOW, BLINK_FAST.
- Replaces ad-hoc edge-toggle LED logic; drives the board LED directly and exposes mode and press events to other logic.

---
 rtl/led_mode_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_led_mode_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_mode_ctrl.sv
// Front-panel push-switch controller: synchronises and debounces one raw
// active-low switch, classifies presses as short or long, and sequences a
// single LED through OFF / ON / BLINK_SLOW / BLINK_FAST.
`timescale 1ns/1ps

module led_mode_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES   = 500000,
  parameter int unsigned LONG_PRESS_CYCLES = 50000000,
  parameter int unsigned SLOW_HALF         = 12500000,
  parameter int unsigned FAST_HALF         = 2500000
) (
  input  logic       clk,
  input  logic       i_Rst_n,
  input  logic       i_Switch_1,
  output logic       o_LED_1,
  output logic [1:0] o_Mode,
  output logic       o_Short_Pulse,
  output logic       o_Long_Pulse
);

  localparam int unsigned DB_W     = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned HOLD_W   = $clog2(LONG_PRESS_CYCLES) + 1;
  localparam int unsigned MAX_HALF = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
  localparam int unsigned PH_W     = $clog2(MAX_HALF) + 1;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_SLOW  = 2'd2,
    MODE_FAST  = 2'd3
  } mode_t;

  logic              sync_1;
  logic              sync_2;
  logic              sw_db;
  logic              sw_db_prev;
  logic [DB_W-1:0]   db_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              long_mark;
  mode_t             mode_q;
  mode_t             mode_d;
  mode_t             led_mode_q;
  logic [PH_W-1:0]   phase_cnt;

  logic              db_diff_c;
  logic              db_accept_c;
  logic              press_start_c;
  logic              short_det_c;
  logic              long_det_c;
  logic [PH_W-1:0]   half_last_c;

  // Two-flop synchroniser for the asynchronous switch; idles released.
  always_ff @(posedge clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
    end else begin
      sync_1 <= i_Switch_1;
      sync_2 <= sync_1;
    end
  end

  // Debounce acceptance: synced level must differ for DEBOUNCE_CYCLES edges.
  always_comb begin
    db_diff_c     = sync_2 ^ sw_db;
    db_accept_c   = db_diff_c && (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
    press_start_c = db_accept_c && !sync_2;
  end

  // Debounced level and its stability counter; counter clears on agreement.
  always_ff @(posedge clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sw_db  <= 1'b1;
      db_cnt <= '0;
    end else if (db_accept_c) begin
      sw_db  <= sync_2;
      db_cnt <= '0;
    end else if (db_diff_c) begin
      db_cnt <= db_cnt + DB_W'(1);
    end else begin
      db_cnt <= '0;
    end
  end

  // Previous debounced level, used to spot the release edge.
  always_ff @(posedge clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sw_db_prev <= 1'b1;
    end else begin
      sw_db_prev <= sw_db;
    end
  end

  // Press events: long once per press at the hold threshold, short on an
  // unmarked release. The two can never coincide (sw_db differs).
  always_comb begin
    long_det_c  = !sw_db && !long_mark && (hold_cnt == HOLD_W'(LONG_PRESS_CYCLES - 1));
    short_det_c = sw_db && !sw_db_prev && !long_mark;
  end

  // Hold counter and long-press mark; a new press restarts both.
  always_ff @(posedge clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      hold_cnt  <= '0;
      long_mark <= 1'b0;
    end else if (press_start_c) begin
      hold_cnt  <= '0;
      long_mark <= 1'b0;
    end else begin
      if (!sw_db && (hold_cnt != HOLD_W'(LONG_PRESS_CYCLES - 1))) begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
      if (long_det_c) begin
        long_mark <= 1'b1;
      end
    end
  end

  // Mode FSM next state: short advances with wrap, long forces OFF.
  always_comb begin
    mode_d = mode_q;
    if (long_det_c) begin
      mode_d = MODE_OFF;
    end else if (short_det_c) begin
      case (mode_q)
        MODE_OFF:  mode_d = MODE_ON;
        MODE_ON:   mode_d = MODE_SLOW;
        MODE_SLOW: mode_d = MODE_FAST;
        MODE_FAST: mode_d = MODE_OFF;
        default:   mode_d = MODE_OFF;
      endcase
    end
  end

  // Mode register and event pulses update on the same edge.
  always_ff @(posedge clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      mode_q        <= MODE_OFF;
      o_Short_Pulse <= 1'b0;
      o_Long_Pulse  <= 1'b0;
    end else begin
      mode_q        <= mode_d;
      o_Short_Pulse <= short_det_c;
      o_Long_Pulse  <= long_det_c;
    end
  end

  assign o_Mode = mode_q;

  // Terminal phase count for the blink mode currently driving the LED.
  always_comb begin
    half_last_c = PH_W'(SLOW_HALF - 1);
    if (led_mode_q == MODE_FAST) begin
      half_last_c = PH_W'(FAST_HALF - 1);
    end
  end

  // LED driver: follows mode one cycle later; blink phase restarts high on
  // every mode change and toggles each half period.
  always_ff @(posedge clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      led_mode_q <= MODE_OFF;
      phase_cnt  <= '0;
      o_LED_1    <= 1'b0;
    end else if (mode_q != led_mode_q) begin
      led_mode_q <= mode_q;
      phase_cnt  <= '0;
      o_LED_1    <= (mode_q != MODE_OFF);
    end else begin
      case (led_mode_q)
        MODE_OFF: begin
          phase_cnt <= '0;
          o_LED_1   <= 1'b0;
        end
        MODE_ON: begin
          phase_cnt <= '0;
          o_LED_1   <= 1'b1;
        end
        default: begin
          if (phase_cnt == half_last_c) begin
            phase_cnt <= '0;
            o_LED_1   <= !o_LED_1;
          end else begin
            phase_cnt <= phase_cnt + PH_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Bench for led_mode_ctrl: directed test-plan steps plus random switch
// activity, checked by a scoreboard fed from a cycle-level reference model.
`timescale 1ns/1ps

module tb_led_mode_ctrl;

  localparam int D  = 4;
  localparam int L  = 20;
  localparam int SH = 8;
  localparam int FH = 3;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       sw    = 1'b1;
  logic       led;
  logic [1:0] mode;
  logic       sp;
  logic       lp;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic       is_long;
    logic [1:0] mode;
  } ev_t;

  ev_t        exp_q[$];
  logic [1:0] exp_mode = 2'd0;
  logic       exp_led  = 1'b0;

  always #5 clk = ~clk;

  led_mode_ctrl #(
    .DEBOUNCE_CYCLES  (D),
    .LONG_PRESS_CYCLES(L),
    .SLOW_HALF        (SH),
    .FAST_HALF        (FH)
  ) dut (
    .clk          (clk),
    .i_Rst_n      (rst_n),
    .i_Switch_1   (sw),
    .o_LED_1      (led),
    .o_Mode       (mode),
    .o_Short_Pulse(sp),
    .o_Long_Pulse (lp)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, req);
    end
  endtask

  // Reference model: a raw level reaches the debounced level once the last D
  // synchronised samples all disagree with it; a press lasting L debounced
  // cycles is long (event at fall+L), a shorter one yields a short event the
  // cycle after release. LED is a function of mode and time since it was set.
  initial begin : model
    bit pipe[$];
    bit win[$];
    bit db;
    bit samp;
    bit all_ne;
    bit long_done;
    int n;
    int fall_edge;
    int rise_edge;
    int m;
    int m_edge;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        pipe = {1'b1, 1'b1};
        win.delete();
        for (int i = 0; i < D; i++) win.push_back(1'b1);
        db        = 1'b1;
        long_done = 1'b0;
        n         = 0;
        fall_edge = -1000;
        rise_edge = -1000;
        m         = 0;
        m_edge    = 0;
        exp_mode  = 2'd0;
        exp_led   = 1'b0;
        exp_q.delete();
      end else begin
        n++;
        case (m)
          0:       exp_led = 1'b0;
          1:       exp_led = 1'b1;
          2:       exp_led = (((n - 1 - m_edge) / SH) % 2) == 0;
          default: exp_led = (((n - 1 - m_edge) / FH) % 2) == 0;
        endcase
        if (!db && !long_done && (n - fall_edge == L)) begin
          long_done = 1'b1;
          if (m != 0) begin
            m      = 0;
            m_edge = n;
          end
          exp_q.push_back('{is_long: 1'b1, mode: 2'd0});
        end else if ((rise_edge == n - 1) && !long_done) begin
          m      = (m + 1) % 4;
          m_edge = n;
          exp_q.push_back('{is_long: 1'b0, mode: 2'(m)});
        end
        samp = pipe.pop_front();
        pipe.push_back(sw);
        void'(win.pop_front());
        win.push_back(samp);
        all_ne = 1'b1;
        foreach (win[i]) if (win[i] == db) all_ne = 1'b0;
        if (all_ne) begin
          db = !db;
          if (!db) begin
            fall_edge = n;
            long_done = 1'b0;
          end else begin
            rise_edge = n;
          end
        end
        exp_mode = 2'(m);
      end
    end
  end

  // Monitor: compares state every cycle and pops the scoreboard per pulse.
  initial begin : monitor
    ev_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_mode", int'(mode), 0);
        check("rst_led", int'(led), 0);
        check("rst_pulses", int'({sp, lp}), 0);
      end else begin
        check("mode", int'(mode), int'(exp_mode));
        check("led", int'(led), int'(exp_led));
        if (sp && lp) begin
          checks++;
          failures++;
          $display("FAIL both_pulses t=%0t actual=short+long required=at most one", $time);
        end else if (sp || lp) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pulse t=%0t actual=short%0d long%0d required=none",
                     $time, sp, lp);
          end else begin
            e = exp_q.pop_front();
            check("pulse_kind_long", int'(lp), int'(e.is_long));
            check("pulse_mode", int'(mode), int'(e.mode));
          end
        end else if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          checks++;
          failures++;
          $display("FAIL missing_pulse t=%0t actual=none required=long%0d mode%0d",
                   $time, e.is_long, e.mode);
        end
      end
    end
  end

  // Called just after a rising edge: hold the switch level for n cycles.
  task automatic hold(input bit v, input int n);
    sw = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic short_press();
    hold(1'b0, 10);
    hold(1'b1, 15);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1);
  end

  initial begin : stim
    int k_seen;
    int lo;
    int hi;
    int r;

    // Reset with switch released, then quiet.
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b1;
    hold(1'b1, 50);
    check("idle_mode", int'(mode), 0);
    check("idle_led", int'(led), 0);

    // Glitch shorter than the debounce window.
    hold(1'b0, 3);
    hold(1'b1, 30);
    check("glitch_mode", int'(mode), 0);

    // Clean short press: pulse 7 cycles after release, LED on one later.
    hold(1'b0, 10);
    sw     = 1'b1;
    k_seen = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (sp && k_seen < 0) begin
        k_seen = k;
        check("short_mode", int'(mode), 1);
      end
      if (k == 8) check("short_led_on", int'(led), 1);
    end
    check("short_latency", k_seen, 7);

    // Walk the remaining modes with dwell time for blink patterns.
    short_press();
    hold(1'b1, 40);
    check("mode_slow", int'(mode), 2);
    short_press();
    hold(1'b1, 20);
    check("mode_fast", int'(mode), 3);
    short_press();
    hold(1'b1, 10);
    check("mode_wrap_off", int'(mode), 0);
    check("led_wrap_off", int'(led), 0);

    // Long press from BLINK_SLOW.
    short_press();
    short_press();
    hold(1'b1, 10);
    sw     = 1'b0;
    k_seen = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (lp && k_seen < 0) begin
        k_seen = k;
        check("long_mode", int'(mode), 0);
      end
      if (k_seen > 0 && k == k_seen + 1) check("long_led_off", int'(led), 0);
      if (k == 30) sw = 1'b1;
    end
    check("long_latency", k_seen, 26);

    // Async reset mid-blink in BLINK_FAST.
    short_press();
    short_press();
    short_press();
    hold(1'b1, 5);
    check("pre_rst_mode", int'(mode), 3);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_led", int'(led), 0);
    check("async_rst_mode", int'(mode), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    hold(1'b1, 30);
    check("post_rst_mode", int'(mode), 0);

    // Random switch activity: glitches, short and long presses, bouncy gaps.
    for (int i = 0; i < 60; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 3)      lo = int'($urandom_range(1, 4));
      else if (r < 7) lo = int'($urandom_range(5, 18));
      else            lo = int'($urandom_range(19, 40));
      hi = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(6, 30));
      hold(1'b0, lo);
      hold(1'b1, hi);
    end

    hold(1'b1, 60);
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
